// File: rtl/seq_shifter_pkg.sv
// Shared op codes and FSM state encoding for the sequential shifter.
// No logic; no latency; no backpressure.
package shifter_pkg;

    localparam logic [2:0] OP_MVB = 3'b000;
    localparam logic [2:0] OP_ASR = 3'b001;
    localparam logic [2:0] OP_LSR = 3'b010;
    localparam logic [2:0] OP_LSL = 3'b011;
    localparam logic [2:0] OP_RSR = 3'b100;
    localparam logic [2:0] OP_RSL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // 11x codes alias MVB, so they take the zero-step path as well.
    function automatic logic is_move(input logic [2:0] op);
        return (op == OP_MVB) || (op[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Request/result bundle between a shift requester and seq_shifter.
// No logic; start is only honoured while busy is low.
interface seq_shifter_if #(
    parameter int BW = 8,
    parameter int AW = $clog2(BW)
);
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] shamt;
    logic [BW-1:0] din;
    logic          busy;
    logic          done;
    logic [BW-1:0] dout;
    logic          c;
    logic          z;

    modport master (
        output start, op, shamt, din,
        input  busy, done, dout, c, z
    );

    modport slave (
        input  start, op, shamt, din,
        output busy, done, dout, c, z
    );
endinterface

// File: rtl/seq_shifter_shift_step.sv
// Single-position shift/rotate of a BW-bit word, with the bit shifted out.
// Combinational, zero latency; no backpressure.
module shift_step
    import shifter_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic [2:0]    op,
    input  logic [BW-1:0] x,
    output logic [BW-1:0] y,
    output logic          k
);

    always_comb begin
        y = x;
        k = 1'b0;
        case (op)
            OP_ASR: begin y = {x[BW-1], x[BW-1:1]}; k = x[0];    end
            OP_LSR: begin y = {1'b0,    x[BW-1:1]}; k = x[0];    end
            OP_LSL: begin y = {x[BW-2:0], 1'b0};    k = x[BW-1]; end
            OP_RSR: begin y = {x[0],    x[BW-1:1]}; k = x[0];    end
            OP_RSL: begin y = {x[BW-2:0], x[BW-1]}; k = x[BW-1]; end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate: one bit position per clock, result on a done pulse.
// Latency shamt+1 cycles to done (1 for zero-step ops); start ignored while busy.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int BW = 8,
    parameter int AW = $clog2(BW)
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_shifter_if.slave  bus
);

    state_t        state_q, state_d;
    logic [AW-1:0] count_q;
    logic [BW-1:0] work_q;
    logic [2:0]    op_q;
    logic [BW-1:0] dout_q;
    logic          c_q;
    logic          z_q;

    logic [BW-1:0] step_y;
    logic          step_k;
    logic          bypass;
    logic          last_step;

    shift_step #(.BW(BW)) u_step (
        .op (op_q),
        .x  (work_q),
        .y  (step_y),
        .k  (step_k)
    );

    assign bypass    = (bus.shamt == '0) || is_move(bus.op);
    assign last_step = (count_q == AW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = bypass ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (last_step) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Result registers load only on the edge that enters DONE, so they hold
    // the previous result throughout SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            work_q  <= '0;
            op_q    <= OP_MVB;
            dout_q  <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        work_q  <= bus.din;
                        op_q    <= bus.op;
                        count_q <= bus.shamt;
                        if (bypass) begin
                            dout_q <= bus.din;
                            c_q    <= 1'b0;
                            z_q    <= (bus.din == '0);
                        end
                    end
                end
                ST_SHIFT: begin
                    work_q  <= step_y;
                    count_q <= count_q - AW'(1);
                    if (last_step) begin
                        dout_q <= step_y;
                        c_q    <= step_k;
                        z_q    <= (step_y == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);
    assign bus.dout = dout_q;
    assign bus.c    = c_q;
    assign bus.z    = z_q;

endmodule
